// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller and the ALU decoder
// that sits downstream of it.
//   - opcode values recognised by the main controller
//   - ALUop encodings consumed by the ALU decoder
//   - ALUSrcB / PCSrc mux select encodings
//   - controller state enum
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD    = 3'b000;
    localparam logic [2:0] ALUOP_SUB_EQ = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT  = 3'b010;
    localparam logic [2:0] ALUOP_SLT    = 3'b011;
    localparam logic [2:0] ALUOP_SUB_NE = 3'b100;
    localparam logic [2:0] ALUOP_OR     = 3'b110;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_WB_R,
        S_BRANCH,
        S_EXEC_I,
        S_WB_I,
        S_JUMP
    } state_t;

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller. Sequences each instruction through
// fetch / decode / execute / memory / writeback and drives every datapath
// enable and mux select, plus ALUop for the ALU decoder. Fetch and
// load/store memory steps stall until mem_ready.
//
// Ports:
//   clk, reset_n        clock (rising edge), async active-low reset
//   op                  opcode from the instruction register
//   mem_ready           memory completes the current access this cycle
//   mem_req, MemWrite   memory request and write strobe
//   IRWrite, IorD       instruction register load, address select
//   PCWrite, Branch, BranchNe   PC load enables
//   RegDst, MemtoReg, RegWrite  register file write controls
//   ALUSrcA, ALUSrcB, ImmZero   ALU operand selects
//   PCSrc, ALUop        next-PC select, ALU decoder operation
//   illegal_op          one-cycle pulse on an unsupported opcode
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 -> PC on mem_ready
// DECODE   | branch target -> ALUOut, dispatch on op
// MEMADR   | A + sign-extended imm -> ALUOut (load/store address)
// MEMRD    | read data memory, wait for mem_ready
// MEMWB    | loaded data -> rt
// MEMWR    | write data memory, wait for mem_ready
// EXEC_R   | A op B per funct
// WB_R     | ALUOut -> rd
// BRANCH   | compare A/B, load PC from ALUOut on condition
// EXEC_I   | A op imm (ADDI / SLTI / ORI)
// WB_I     | ALUOut -> rt
// JUMP     | jump target -> PC
module mc_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               IorD,
    output logic               PCWrite,
    output logic               Branch,
    output logic               BranchNe,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ImmZero,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal_op
);

    state_t state, state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:             state_next = S_MEMADR;
                    OP_RTYPE:                 state_next = S_EXEC_R;
                    OP_BEQ, OP_BNE:           state_next = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ORI: state_next = S_EXEC_I;
                    OP_J:                     state_next = S_JUMP;
                    default:                  state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      state_next = S_MEMRD;
                else if (op == OP_SW) state_next = S_MEMWR;
                else                  state_next = S_FETCH;
            end
            S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  if (mem_ready) state_next = S_FETCH;
            S_EXEC_R: state_next = S_WB_R;
            S_WB_R:   state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_EXEC_I: state_next = S_WB_I;
            S_WB_I:   state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Outputs are gated by reset_n so that every control is inactive while
    // reset is held, even though the state register already reads FETCH.
    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        BranchNe   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ImmZero    = 1'b0;
        PCSrc      = PCSRC_ALU;
        ALUop      = ALUOP_ADD;
        illegal_op = 1'b0;
        if (reset_n) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    // IR and PC load only on the acknowledged cycle.
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMM_SH2;
                    case (op)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
                        OP_ADDI, OP_SLTI, OP_ORI, OP_J: illegal_op = 1'b0;
                        default:                        illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUop   = ALUOP_FUNCT;
                end
                S_WB_R: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    PCSrc   = PCSRC_ALUOUT;
                    if (op == OP_BNE) begin
                        ALUop    = ALUOP_SUB_NE;
                        BranchNe = 1'b1;
                    end else if (op == OP_BEQ) begin
                        ALUop  = ALUOP_SUB_EQ;
                        Branch = 1'b1;
                    end
                end
                S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    case (op)
                        OP_SLTI: ALUop = ALUOP_SLT;
                        OP_ORI: begin
                            ALUop   = ALUOP_OR;
                            ImmZero = 1'b1;
                        end
                        default: ALUop = ALUOP_ADD;
                    endcase
                end
                S_WB_I: begin
                    RegWrite = 1'b1;
                end
                S_JUMP: begin
                    PCSrc   = PCSRC_JUMP;
                    PCWrite = 1'b1;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       iord;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zero;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       illegal;
    } ctl_t;

    localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011,
                           BEQ_OP = 6'b000100, BNE_OP = 6'b000101, ADDI_OP = 6'b001000,
                           SLTI_OP = 6'b001010, ORI_OP = 6'b001101, J_OP = 6'b000010;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, MemWrite, IRWrite, IorD, PCWrite, Branch, BranchNe;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, ImmZero, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUop;

    int errors = 0;
    int checks = 0;

    ctl_t  exp_q[$];
    string tag_q[$];
    ctl_t  act;

    mc_ctrl_fsm dut (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .IorD(IorD),
        .PCWrite(PCWrite), .Branch(Branch), .BranchNe(BranchNe), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmZero(ImmZero), .PCSrc(PCSrc), .ALUop(ALUop), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign act = {mem_req, MemWrite, IRWrite, IorD, PCWrite, Branch, BranchNe,
                  RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ImmZero, PCSrc,
                  ALUop, illegal_op};

    // Monitor: one expected control word per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", t, act, e);
            end
        end
    end

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {R_OP, LW_OP, SW_OP, BEQ_OP, BNE_OP, ADDI_OP, SLTI_OP, ORI_OP, J_OP};
    endfunction

    function automatic ctl_t fetch_ctl(input logic ack);
        ctl_t e = '0;
        e.mem_req   = 1'b1;
        e.alu_src_b = 2'b01;
        e.ir_write  = ack;
        e.pc_write  = ack;
        return e;
    endfunction

    task automatic step(input logic rv, input logic [5:0] ov, input logic mr,
                        input ctl_t e, input string tag);
        @(posedge clk);
        #1;
        reset_n   = rv;
        op        = ov;
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Reference model: expands one instruction into its per-cycle controls
    // from the instruction's semantics, with fw fetch stalls and mw data stalls.
    task automatic run_instr(input logic [5:0] o, input int fw, input int mw);
        ctl_t e;
        for (int i = 0; i < fw; i++)
            step(1'b1, 6'($urandom), 1'b0, fetch_ctl(1'b0), "fetch_wait");
        step(1'b1, 6'($urandom), 1'b1, fetch_ctl(1'b1), "fetch_ack");
        e = '0;
        e.alu_src_b = 2'b11;
        e.illegal   = !is_legal(o);
        step(1'b1, o, rnd_bit(), e, "decode");
        if (o == LW_OP || o == SW_OP) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            step(1'b1, o, rnd_bit(), e, "memadr");
            e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = (o == SW_OP);
            for (int i = 0; i < mw; i++)
                step(1'b1, o, 1'b0, e, (o == SW_OP) ? "memwr_wait" : "memrd_wait");
            step(1'b1, o, 1'b1, e, (o == SW_OP) ? "memwr_ack" : "memrd_ack");
            if (o == LW_OP) begin
                e = '0; e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
                step(1'b1, o, rnd_bit(), e, "lw_writeback");
            end
        end else if (o == R_OP) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_op = 3'b010;
            step(1'b1, o, rnd_bit(), e, "exec_r");
            e = '0; e.reg_dst = 1'b1; e.reg_write = 1'b1;
            step(1'b1, o, rnd_bit(), e, "wb_r");
        end else if (o == BEQ_OP || o == BNE_OP) begin
            e = '0; e.alu_src_a = 1'b1; e.pc_src = 2'b01;
            e.alu_op    = (o == BEQ_OP) ? 3'b001 : 3'b100;
            e.branch    = (o == BEQ_OP);
            e.branch_ne = (o == BNE_OP);
            step(1'b1, o, rnd_bit(), e, "branch");
        end else if (o == ADDI_OP || o == SLTI_OP || o == ORI_OP) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            e.alu_op   = (o == SLTI_OP) ? 3'b011 : (o == ORI_OP) ? 3'b110 : 3'b000;
            e.imm_zero = (o == ORI_OP);
            step(1'b1, o, rnd_bit(), e, "exec_i");
            e = '0; e.reg_write = 1'b1;
            step(1'b1, o, rnd_bit(), e, "wb_i");
        end else if (o == J_OP) begin
            e = '0; e.pc_src = 2'b10; e.pc_write = 1'b1;
            step(1'b1, o, rnd_bit(), e, "jump");
        end
    endtask

    initial begin
        logic [5:0] legal_ops [9];
        logic [5:0] o;
        ctl_t       e;
        legal_ops = '{R_OP, LW_OP, SW_OP, BEQ_OP, BNE_OP, ADDI_OP, SLTI_OP, ORI_OP, J_OP};

        step(1'b0, 6'($urandom), 1'b1, '0, "held_in_reset");

        run_instr(LW_OP, 0, 0);
        run_instr(SW_OP, 0, 3);
        run_instr(R_OP, 0, 0);
        run_instr(BEQ_OP, 0, 0);
        run_instr(BNE_OP, 0, 0);
        run_instr(ORI_OP, 0, 0);
        run_instr(SLTI_OP, 0, 0);
        run_instr(ADDI_OP, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(J_OP, 0, 0);
        run_instr(LW_OP, 2, 2);

        // Reset asserted while the R-type is in its execute step.
        step(1'b1, 6'($urandom), 1'b1, fetch_ctl(1'b1), "fetch_ack");
        e = '0; e.alu_src_b = 2'b11;
        step(1'b1, R_OP, 1'b0, e, "decode");
        step(1'b0, R_OP, 1'b1, '0, "reset_mid_exec_r");
        run_instr(ADDI_OP, 0, 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do o = 6'($urandom); while (is_legal(o));
            end else begin
                o = legal_ops[$urandom_range(0, 8)];
            end
            run_instr(o, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                         ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
